// File: rtl/decode_queue_pkg.sv
// Shared types and constants for the decode-stage front end: RV32I opcodes,
// micro-op classes and the queued fetch entry.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_R   = 4'd0,
    ALU_I   = 4'd1,
    LOAD    = 4'd2,
    STORE   = 4'd3,
    BRANCH  = 4'd4,
    JAL     = 4'd5,
    JALR    = 4'd6,
    LUI     = 4'd7,
    AUIPC   = 4'd8,
    SYSTEM  = 4'd9,
    ILLEGAL = 4'd10
  } uop_class_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-to-decode and decode-to-issue handshake bundle.
// Valid/ready: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid && !ready.
interface decode_queue_if;
  import decode_pkg::*;

  logic        IF_valid;
  logic [15:0] IF_out_pc;
  logic [31:0] IF_out_inst;
  logic        DC_ready;

  logic        DC_valid;
  logic        IS_ready;
  logic [15:0] DC_pc;
  logic [31:0] DC_inst;
  logic [4:0]  DC_rd;
  logic [4:0]  DC_rs1;
  logic [4:0]  DC_rs2;
  logic [2:0]  DC_funct3;
  logic [6:0]  DC_funct7;
  logic [31:0] DC_imm;
  uop_class_t  DC_class;
  logic        DC_illegal;

  modport master (
    output IF_valid, IF_out_pc, IF_out_inst, IS_ready,
    input  DC_ready, DC_valid, DC_pc, DC_inst, DC_rd, DC_rs1, DC_rs2,
           DC_funct3, DC_funct7, DC_imm, DC_class, DC_illegal
  );

  modport slave (
    input  IF_valid, IF_out_pc, IF_out_inst, IS_ready,
    output DC_ready, DC_valid, DC_pc, DC_inst, DC_rd, DC_rs1, DC_rs2,
           DC_funct3, DC_funct7, DC_imm, DC_class, DC_illegal
  );
endinterface

// File: rtl/decode_queue_decoder.sv
// Combinational RV32I field extraction, immediate generation and micro-op
// classification for one instruction word.
module rv32i_decoder
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output uop_class_t  uop_class,
  output logic        illegal
);

  imm_fmt_t fmt;

  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    fmt       = IMM_NONE;
    uop_class = ILLEGAL;
    case (inst[6:0])
      OP_OP:     begin uop_class = ALU_R;  fmt = IMM_NONE; end
      OP_IMM:    begin uop_class = ALU_I;  fmt = IMM_I;    end
      OP_LOAD:   begin uop_class = LOAD;   fmt = IMM_I;    end
      OP_STORE:  begin uop_class = STORE;  fmt = IMM_S;    end
      OP_BRANCH: begin uop_class = BRANCH; fmt = IMM_B;    end
      OP_JAL:    begin uop_class = JAL;    fmt = IMM_J;    end
      OP_JALR:   begin uop_class = JALR;   fmt = IMM_I;    end
      OP_LUI:    begin uop_class = LUI;    fmt = IMM_U;    end
      OP_AUIPC:  begin uop_class = AUIPC;  fmt = IMM_U;    end
      OP_SYSTEM: begin uop_class = SYSTEM; fmt = IMM_NONE; end
      default:   begin uop_class = ILLEGAL; fmt = IMM_NONE; end
    endcase
  end

  // Every format sign-extends from inst[31]; B and J carry an implicit zero LSB.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign illegal = (inst[1:0] != 2'b11) || (uop_class == ILLEGAL);

endmodule

// File: rtl/decode_queue.sv
// Decode-stage front end: in-order circular queue of fetched (pc, inst) pairs
// with the head entry decoded toward issue. DEPTH must be a power of two >= 2.
module decode_queue
  import decode_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mispredict,
  decode_queue_if.slave   bus,
  output logic [CW-1:0]   dbg_count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  fq_entry_t       head;

  // Ready/valid come from registered count only, so a full queue refuses a
  // push even when the head is popped in the same cycle.
  assign bus.DC_ready = (count != FULL);
  assign bus.DC_valid = (count != '0);

  assign push = bus.IF_valid && bus.DC_ready && !mispredict;
  assign pop  = bus.DC_valid && bus.IS_ready && !mispredict;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: bus.IF_out_pc, inst: bus.IF_out_inst};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign bus.DC_pc   = head.pc;
  assign bus.DC_inst = head.inst;
  assign dbg_count   = count;

  rv32i_decoder u_dec (
    .inst      (head.inst),
    .rd        (bus.DC_rd),
    .rs1       (bus.DC_rs1),
    .rs2       (bus.DC_rs2),
    .funct3    (bus.DC_funct3),
    .funct7    (bus.DC_funct7),
    .imm       (bus.DC_imm),
    .uop_class (bus.DC_class),
    .illegal   (bus.DC_illegal)
  );

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed handshake/flush/decode cases
// plus a randomized push/pop run against a queue-based reference model.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W     = 48;

  logic          clk;
  logic          rst;
  logic          mispredict;
  logic [CW-1:0] dbg_count;

  decode_queue_if bus ();

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mispredict (mispredict),
    .bus        (bus),
    .dbg_count  (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected queue contents as {pc, inst}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference decode, built arithmetically from the RV32I immediate layouts
  function automatic uop_class_t ref_class(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return ALU_R;
      7'b0010011: return ALU_I;
      7'b0000011: return LOAD;
      7'b0100011: return STORE;
      7'b1100011: return BRANCH;
      7'b1101111: return JAL;
      7'b1100111: return JALR;
      7'b0110111: return LUI;
      7'b0010111: return AUIPC;
      7'b1110011: return SYSTEM;
      default:    return ILLEGAL;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int sgn;
    int v;
    sgn = int'(i[31]) * -1;
    v   = 0;
    case (ref_class(i))
      ALU_I, LOAD, JALR: v = sgn * 2048 + int'(i[30:20]);
      STORE:  v = sgn * 2048 + int'(i[30:25]) * 32 + int'(i[11:7]);
      BRANCH: v = sgn * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      LUI, AUIPC: v = int'(i & 32'hFFFF_F000);
      JAL:    v = sgn * (1 << 20) + int'(i[19:12]) * (1 << 12) + int'(i[20]) * 2048
                  + int'(i[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic compare_outputs();
    logic [W-1:0] h;
    check("dc_ready", bus.DC_ready, exp_q.size() != DEPTH);
    check("dc_valid", bus.DC_valid, exp_q.size() != 0);
    check("count", dbg_count, exp_q.size());
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("head_pc", bus.DC_pc, h[47:32]);
      check("head_inst", bus.DC_inst, h[31:0]);
      check("head_rd", bus.DC_rd, (h[31:0] >> 7) & 32'h1F);
      check("head_rs1", bus.DC_rs1, (h[31:0] >> 15) & 32'h1F);
      check("head_rs2", bus.DC_rs2, (h[31:0] >> 20) & 32'h1F);
      check("head_f3", bus.DC_funct3, (h[31:0] >> 12) & 32'h7);
      check("head_f7", bus.DC_funct7, h[31:0] >> 25);
      check("head_imm", bus.DC_imm, ref_imm(h[31:0]));
      check("head_class", bus.DC_class, ref_class(h[31:0]));
      check("head_illegal", bus.DC_illegal, ref_class(h[31:0]) == ILLEGAL);
    end
  endtask

  // driver: one clock cycle of stimulus, checked mid-cycle, model stepped at the edge
  task automatic cycle(input logic ifv, input logic [15:0] pc, input logic [31:0] inst,
                       input logic isr, input logic misp);
    bit do_push;
    bit do_pop;
    bus.IF_valid    = ifv;
    bus.IF_out_pc   = pc;
    bus.IF_out_inst = inst;
    bus.IS_ready    = isr;
    mispredict      = misp;
    @(negedge clk);
    compare_outputs();
    do_push = ifv && (exp_q.size() != DEPTH) && !misp;
    do_pop  = isr && (exp_q.size() != 0) && !misp;
    @(posedge clk);
    if (misp) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, inst});
    end
    #1;
  endtask

  task automatic idle(input logic isr);
    cycle(1'b0, 16'h0, 32'h0, isr, 1'b0);
  endtask

  logic [6:0] op_tab [11];
  initial begin
    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
               7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111};
  end

  initial begin
    int          n_acc;
    int          cyc;
    logic [15:0] next_pc;
    logic [31:0] r;
    logic        ifv;
    logic        isr;

    rst = 1'b1;
    mispredict = 1'b0;
    bus.IF_valid = 1'b0;
    bus.IF_out_pc = '0;
    bus.IF_out_inst = '0;
    bus.IS_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state: empty queue, zero entry at the head
    check("rst_valid", bus.DC_valid, 0);
    check("rst_ready", bus.DC_ready, 1);
    check("rst_pc", bus.DC_pc, 0);
    check("rst_inst", bus.DC_inst, 0);
    check("rst_imm", bus.DC_imm, 0);
    check("rst_illegal", bus.DC_illegal, 1);
    check("rst_class", bus.DC_class, ILLEGAL);

    // addi x1,x0,5 visible one cycle after the push, popped the cycle after
    cycle(1'b1, 16'h0000, 32'h0050_0093, 1'b1, 1'b0);
    check("addi_valid", bus.DC_valid, 1);
    check("addi_rd", bus.DC_rd, 1);
    check("addi_rs1", bus.DC_rs1, 0);
    check("addi_imm", bus.DC_imm, 5);
    check("addi_class", bus.DC_class, ALU_I);
    idle(1'b1);
    check("addi_popped", bus.DC_valid, 0);

    // fill with issue stalled; the fifth offer is ignored
    for (int k = 1; k <= 4; k++) cycle(1'b1, 16'(4 * k), 32'h0000_0013 | (32'(k) << 7), 1'b0, 1'b0);
    check("full_ready", bus.DC_ready, 0);
    cycle(1'b1, 16'h0014, 32'h0000_0013, 1'b0, 1'b0);
    check("full_head_pc", bus.DC_pc, 16'h0004);
    check("full_count", dbg_count, 4);

    // pop while full: no push that cycle, push succeeds next cycle
    cycle(1'b1, 16'h0018, 32'h0000_0033, 1'b1, 1'b0);
    check("pop_full_ready", bus.DC_ready, 1);
    check("pop_full_count", dbg_count, 3);
    check("pop_full_head", bus.DC_pc, 16'h0008);
    cycle(1'b1, 16'h0018, 32'h0000_0033, 1'b0, 1'b0);
    check("refill_count", dbg_count, 4);

    // flush with 3 entries and a concurrent fetch offer
    idle(1'b1);
    check("pre_flush_count", dbg_count, 3);
    cycle(1'b1, 16'h001C, 32'h0000_0013, 1'b1, 1'b1);
    check("flush_valid", bus.DC_valid, 0);
    check("flush_count", dbg_count, 0);
    check("flush_ready", bus.DC_ready, 1);
    cycle(1'b1, 16'h0040, 32'h0000_0013, 1'b0, 1'b0);
    check("post_flush_valid", bus.DC_valid, 1);
    check("post_flush_pc", bus.DC_pc, 16'h0040);
    idle(1'b1);

    // directed decode cases; 0xFE000EE3 has inst[7]=1 so imm[11]=1, giving -4
    cycle(1'b1, 16'h0044, 32'hFE00_0EE3, 1'b0, 1'b0);
    check("beq_imm", bus.DC_imm, 32'hFFFF_FFFC);
    check("beq_class", bus.DC_class, BRANCH);
    cycle(1'b1, 16'h0048, 32'h8000_00EF, 1'b1, 1'b0);
    check("jal_imm", bus.DC_imm, 32'hFFF0_0000);
    check("jal_class", bus.DC_class, JAL);
    cycle(1'b1, 16'h004C, 32'h0000_0000, 1'b1, 1'b0);
    check("zero_illegal", bus.DC_illegal, 1);
    check("zero_class", bus.DC_class, ILLEGAL);
    idle(1'b1);
    idle(1'b1);

    // randomized back-to-back traffic across pointer wrap
    n_acc = 0;
    cyc = 0;
    next_pc = 16'h0100;
    while (n_acc < 100 && cyc < 3000) begin
      ifv = ($urandom_range(0, 3) != 0);
      isr = ($urandom_range(0, 2) != 0);
      r = $urandom();
      if ($urandom_range(0, 4) != 0) r[6:0] = op_tab[$urandom_range(0, 10)];
      if (ifv && exp_q.size() != DEPTH) begin
        cycle(1'b1, next_pc, r, isr, 1'b0);
        next_pc = next_pc + 16'd4;
        n_acc++;
      end else begin
        cycle(ifv, next_pc, r, isr, 1'b0);
      end
      cyc++;
    end
    check("rand_accepted", n_acc, 100);
    for (int k = 0; k < 3 * DEPTH && exp_q.size() != 0; k++) idle(1'b1);
    check("drained_valid", bus.DC_valid, 0);
    check("drained_count", dbg_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // absolute time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (limit reached)");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
